// File: rtl/instruction_fetch_unit.sv
// Instruction fetch initiator: issues SETUP/READ memory cycles, buffers returned
// words in a small prefetch FIFO and hands them to decode with valid/ready.
module instruction_fetch_unit #(
  parameter int unsigned   AW       = 16,
  parameter int unsigned   DW       = 16,
  parameter int unsigned   DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [AW-1:0] ADDBUS,
  output logic          RD,
  input  logic [DW-1:0] DATAIN,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [DW-1:0] ins_out,
  output logic [AW-1:0] pc_out,
  output logic          ins_valid,
  input  logic          ins_ready,
  output logic          busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SETUP, READ} state_t;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] ins;
  } entry_t;

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   pc;
  logic [AW-1:0]   pc_nxt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   rd_ptr_nxt;
  entry_t          mem [DEPTH];
  entry_t          push_entry;
  entry_t          head_nxt;
  logic            head_load;
  logic            push;
  logic            pop;
  logic            room;
  logic            rd_nxt;
  logic            busy_nxt;
  logic            addr_load;

  // Datapath: FIFO occupancy, PC and next head after this cycle's push/pop
  always_comb begin
    pop        = ins_valid & ins_ready;
    push       = (state == READ) & ~redirect;
    push_entry = '{pc: pc, ins: DATAIN};
    rd_ptr_nxt = rd_ptr + PW'(pop);
    count_nxt  = count + CW'(push) - CW'(pop);
    room       = count_nxt < CW'(DEPTH);
    pc_nxt     = pc;
    head_nxt   = '{pc: pc_out, ins: ins_out};
    head_load  = 1'b0;
    if (redirect) begin
      count_nxt = '0;
      pc_nxt    = redirect_pc;
    end else begin
      if (push) begin
        pc_nxt = AW'(pc + AW'(1));
      end
      if (count_nxt != '0) begin
        head_load = 1'b1;
        // Incoming word becomes head when nothing older survives this cycle
        if ((count - CW'(pop)) == '0) begin
          head_nxt = push_entry;
        end else begin
          head_nxt = mem[rd_ptr_nxt];
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; redirect overrides everything
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && room) state_nxt = SETUP;
      SETUP:   state_nxt = READ;
      READ:    state_nxt = (en && room) ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (redirect) begin
      state_nxt = en ? SETUP : IDLE;
    end
  end

  // Output decode for the registered bus outputs
  always_comb begin
    rd_nxt    = 1'b0;
    busy_nxt  = 1'b0;
    addr_load = 1'b0;
    if (state_nxt == READ) begin
      rd_nxt = 1'b1;
    end
    if (state_nxt != IDLE) begin
      busy_nxt = 1'b1;
    end
    // Address follows PC on entering SETUP and when a read retires
    if ((state_nxt == SETUP) || push) begin
      addr_load = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      ADDBUS    <= '0;
      RD        <= 1'b0;
      busy      <= 1'b0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ins_valid <= 1'b0;
      ins_out   <= '0;
      pc_out    <= '0;
    end else begin
      pc        <= pc_nxt;
      RD        <= rd_nxt;
      busy      <= busy_nxt;
      count     <= count_nxt;
      ins_valid <= (count_nxt != '0);
      if (addr_load) begin
        ADDBUS <= pc_nxt;
      end
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        wr_ptr <= wr_ptr + PW'(push);
        rd_ptr <= rd_ptr_nxt;
      end
      if (head_load) begin
        ins_out <= head_nxt.ins;
        pc_out  <= head_nxt.pc;
      end
    end
  end

  // FIFO storage needs no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a memory model feeds DATAIN and a
// scoreboard of expected {pc,ins} words is checked on every core handshake.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] ADDBUS;
  logic        RD;
  logic [15:0] DATAIN;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] ins_out;
  logic [15:0] pc_out;
  logic        ins_valid;
  logic        ins_ready;
  logic        busy;

  int          n_cmp;
  int          n_err;
  logic [31:0] q[$];
  logic [15:0] exp_pc;
  logic        prev_rd;
  logic [31:0] ent;
  bit          hit;

  instruction_fetch_unit #(
    .AW(16), .DW(16), .DEPTH(2), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ADDBUS(ADDBUS), .RD(RD),
    .DATAIN(DATAIN), .redirect(redirect), .redirect_pc(redirect_pc),
    .ins_out(ins_out), .pc_out(pc_out), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .busy(busy)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: return 16'd0;
      16'h0001: return 16'd12292;
      16'h0002: return 16'd8342;
      16'h0020: return 16'd8342;
      default:  return 16'(a * 16'd7) ^ 16'h5A3C;
    endcase
  endfunction

  assign DATAIN = RD ? mem_word(ADDBUS) : 16'hDEAD;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: queue an expected word per memory read, compare on each pop
  task automatic mon_step();
    if (rst_n !== 1'b1) begin
      prev_rd = 1'b0;
      return;
    end
    if (RD === 1'b1) begin
      check("rd_low_between_reads", 32'(prev_rd), 32'd0);
      check("addbus_at_read", 32'(ADDBUS), 32'(exp_pc));
      q.push_back({exp_pc, mem_word(exp_pc)});
      exp_pc = exp_pc + 16'd1;
    end
    prev_rd = RD;
    if (ins_valid === 1'b1 && ins_ready === 1'b1) begin
      if (q.size() == 0) begin
        check("sb_unexpected_word", {pc_out, ins_out}, 32'hFFFF_FFFF);
      end else begin
        ent = q.pop_front();
        check("sb_pc_out", 32'(pc_out), 32'(ent[31:16]));
        check("sb_ins_out", 32'(ins_out), 32'(ent[15:0]));
      end
    end
  endtask

  task automatic wait_rd(input logic lvl, input int max, input string tag);
    hit = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (RD === lvl) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_valid(input int max, input string tag);
    hit = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (ins_valid === 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_sb(input logic [15:0] new_pc);
    q.delete();
    exp_pc = new_pc;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    exp_pc = 16'h0000;
    prev_rd = 1'b0;
    rst_n = 1'b0;
    en = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    ins_ready = 1'b0;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    // Reset values
    #2;
    check("rst_ADDBUS", 32'(ADDBUS), 32'd0);
    check("rst_RD", 32'(RD), 32'd0);
    check("rst_ins_valid", 32'(ins_valid), 32'd0);
    check("rst_ins_out", 32'(ins_out), 32'd0);
    check("rst_pc_out", 32'(pc_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Sequential fetch: RD toggles every other cycle after the SETUP latency
    en = 1'b1;
    ins_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("seq_rd_cycle%0d", i), 32'(RD), 32'((i >= 2) && (i % 2 == 0)));
      if (i == 1) check("seq_busy", 32'(busy), 32'd1);
    end

    // Backpressure from a fresh start at 0
    tick();
    ins_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 16'h0000;
    tick();
    redirect = 1'b0;
    flush_sb(16'h0000);
    repeat (8) @(negedge clk);
    check("bp_RD", 32'(RD), 32'd0);
    check("bp_ADDBUS", 32'(ADDBUS), 32'd2);
    check("bp_busy", 32'(busy), 32'd0);
    check("bp_ins_valid", 32'(ins_valid), 32'd1);
    check("bp_head_pc", 32'(pc_out), 32'd0);
    tick();
    ins_ready = 1'b1;

    // Redirect during the READ of PC 5
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (RD === 1'b1 && ADDBUS === 16'h0005) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check("redir_read5_timeout", 32'd0, 32'd1);
    redirect = 1'b1;
    redirect_pc = 16'h0020;
    tick();
    redirect = 1'b0;
    flush_sb(16'h0020);
    wait_valid(10, "redir_first");
    check("redir_head_ins", 32'(ins_out), 32'd8342);
    check("redir_head_pc", 32'(pc_out), 32'h20);

    // Address wrap at the top of the space
    tick();
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect = 1'b0;
    flush_sb(16'hFFFF);
    wait_rd(1'b1, 10, "wrap_rd1");
    check("wrap_addr_ffff", 32'(ADDBUS), 32'hFFFF);
    wait_rd(1'b0, 10, "wrap_rd0");
    wait_rd(1'b1, 10, "wrap_rd2");
    check("wrap_addr_0000", 32'(ADDBUS), 32'h0000);

    // Redirect with a full FIFO and a pop in the same cycle
    tick();
    ins_ready = 1'b0;
    repeat (8) @(negedge clk);
    check("full_ins_valid", 32'(ins_valid), 32'd1);
    check("full_RD", 32'(RD), 32'd0);
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    ins_ready = 1'b1;
    tick();
    redirect = 1'b0;
    flush_sb(16'h0040);
    @(negedge clk);
    check("flush_ins_valid", 32'(ins_valid), 32'd0);
    check("flush_busy", 32'(busy), 32'd1);
    wait_valid(10, "flush_refetch");
    check("flush_refetch_pc", 32'(pc_out), 32'h40);

    // Asynchronous reset in the middle of a READ
    wait_rd(1'b1, 10, "mid_read");
    rst_n = 1'b0;
    #1;
    check("arst_RD", 32'(RD), 32'd0);
    check("arst_ins_valid", 32'(ins_valid), 32'd0);
    check("arst_ADDBUS", 32'(ADDBUS), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    tick();
    flush_sb(16'h0000);
    tick();
    rst_n = 1'b1;
    wait_rd(1'b1, 10, "post_rst_rd");
    check("post_rst_addr", 32'(ADDBUS), 32'h0000);

    // Drain: en low lets the current read finish, then everything empties
    tick();
    en = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && ins_valid === 1'b0) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) check("drain_timeout", 32'd0, 32'd1);
    check("drain_sb_empty", 32'(q.size()), 32'd0);
    repeat (3) @(negedge clk);
    check("idle_RD", 32'(RD), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
